// File: rtl/mem_subsys.sv
// Unified single-port memory serving an instruction port and a data port with
// arbitration, configurable wait states and byte-enabled writes.
module mem_subsys #(
   parameter int    ADDR_W        = 32,
   parameter int    DATA_W        = 32,
   parameter int    DEPTH         = 1024,
   parameter int    WAIT_STATES   = 1,
   parameter int    DATA_PRIORITY = 1,
   parameter string INIT_FILE     = ""
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_req,
   input  logic [ADDR_W-1:0]     i_addr,
   output logic [DATA_W-1:0]     i_rdata,
   output logic                  i_ready,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [DATA_W/8-1:0]   d_be,
   input  logic [ADDR_W-1:0]     d_addr,
   input  logic [DATA_W-1:0]     d_wdata,
   output logic [DATA_W-1:0]     d_rdata,
   output logic                  d_ready,
   output logic                  stall,
   output logic [1:0]            dbg_state_o
);

   localparam int BE_W  = DATA_W / 8;
   localparam int OFF_W = $clog2(BE_W);
   localparam int IDX_W = $clog2(DEPTH);

   // dbg_state_o encoding: 0 = idle, 1 = waiting, 2 = done
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                sel_d_q, sel_d_d;
   logic                prio_d_q, prio_d_d;
   logic                we_q, we_d;
   logic [BE_W-1:0]     be_q, be_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                i_ready_q, i_ready_d;
   logic                d_ready_q, d_ready_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic [ADDR_W-1:0]   i_word, d_word;
   logic                any_req, grant_d, accept, commit;
   logic                unused_addr_bits;

   // Byte offset bits and bits above the array size are don't-care.
   assign i_word           = i_addr >> OFF_W;
   assign d_word           = d_addr >> OFF_W;
   assign unused_addr_bits = ^{i_word, d_word};

   assign any_req = i_req | d_req;
   // prio_d_q remembers which port lost last time; only consulted in round-robin mode.
   assign grant_d = d_req & (~i_req | (DATA_PRIORITY != 0) | prio_d_q);
   assign accept  = (state_q == ST_IDLE) && any_req;
   assign commit  = (state_q == ST_WAIT) && (cnt_q == 4'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 4'd0;
         sel_d_q   <= 1'b0;
         prio_d_q  <= 1'b1;
         we_q      <= 1'b0;
         be_q      <= '0;
         wdata_q   <= '0;
         idx_q     <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         i_ready_q <= 1'b0;
         d_ready_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sel_d_q   <= sel_d_d;
         prio_d_q  <= prio_d_d;
         we_q      <= we_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         idx_q     <= idx_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         i_ready_q <= i_ready_d;
         d_ready_q <= d_ready_d;
      end
   end

   // A reset landing on the commit edge suppresses the write.
   always_ff @(posedge clk) begin
      if (commit && we_q && !reset) begin
         for (int b = 0; b < BE_W; b++) begin
            if (be_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (any_req) state_d = ST_WAIT;
         ST_WAIT: if (cnt_q == 4'd0) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d     = cnt_q;
      sel_d_d   = sel_d_q;
      prio_d_d  = prio_d_q;
      we_d      = we_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      idx_d     = idx_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      i_ready_d = 1'b0;
      d_ready_d = 1'b0;
      if (accept) begin
         sel_d_d  = grant_d;
         prio_d_d = ~grant_d;
         idx_d    = grant_d ? d_word[IDX_W-1:0] : i_word[IDX_W-1:0];
         we_d     = grant_d & d_we;
         be_d     = d_be;
         wdata_d  = d_wdata;
         cnt_d    = 4'(WAIT_STATES);
      end
      if ((state_q == ST_WAIT) && (cnt_q != 4'd0)) cnt_d = cnt_q - 4'd1;
      if (commit) begin
         i_ready_d = ~sel_d_q;
         d_ready_d = sel_d_q;
         if (!we_q) begin
            if (sel_d_q) d_rdata_d = mem_q[idx_q];
            else         i_rdata_d = mem_q[idx_q];
         end
      end
   end

   assign i_rdata     = i_rdata_q;
   assign d_rdata     = d_rdata_q;
   assign i_ready     = i_ready_q;
   assign d_ready     = d_ready_q;
   assign stall       = (i_req & ~i_ready_q) | (d_req & ~d_ready_q);
   assign dbg_state_o = state_q;

endmodule
